// File: rtl/fcvt_i2f.sv
// fcvt_i2f: multi-cycle 32-bit integer to IEEE-754 binary32 converter.
// The magnitude is normalised one bit per cycle, then rounded in a single
// cycle according to the captured rounding mode.
//
// Ports:
//   clk_i     clock, all state updates on the rising edge
//   rst_i     synchronous active-high reset
//   start_i   conversion request, only looked at while idle
//   int_i     32-bit integer operand, captured on accept
//   signed_i  1 = two's-complement operand, 0 = unsigned; captured on accept
//   rm_i      rounding mode (RNE, RTZ, RDN, RUP, RMM; other codes truncate)
//   busy_o    high while a conversion is in flight
//   done_o    one-cycle pulse when result_o/nx_o are updated
//   result_o  binary32 result, held until the next done_o
//   nx_o      inexact flag, held with result_o
module fcvt_i2f (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] int_i,
    input  logic        signed_i,
    input  logic [2:0]  rm_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        nx_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2
    } state_t;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    state_t      state_r;
    state_t      state_next_s;
    logic        busy_r;
    logic        done_r;
    logic [31:0] result_r;
    logic        nx_r;
    logic        sign_r;
    logic [31:0] mag_r;
    logic [2:0]  rm_r;
    logic [7:0]  exp_r;

    logic        sign_in_s;
    logic [31:0] mag_in_s;
    logic        round_bit_s;
    logic        sticky_s;
    logic        inexact_s;
    logic        round_up_s;
    logic [23:0] sig_sum_s;
    logic [22:0] sig_final_s;
    logic [7:0]  exp_final_s;
    logic [31:0] packed_s;

    // Decides whether the truncated significand is bumped by one ulp.
    function automatic logic round_up_f(input logic [2:0] rm, input logic sign,
                                        input logic rnd, input logic sticky,
                                        input logic lsb);
        logic up;
        case (rm)
            RM_RNE:  up = rnd & (sticky | lsb);
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = sign & (rnd | sticky);
            RM_RUP:  up = ~sign & (rnd | sticky);
            RM_RMM:  up = rnd;
            default: up = 1'b0;
        endcase
        return up;
    endfunction

    // Operand conditioning at accept: sign extraction and magnitude.
    always_comb begin
        sign_in_s = signed_i & int_i[31];
        if (sign_in_s) begin
            mag_in_s = ~int_i + 32'd1;
        end else begin
            mag_in_s = int_i;
        end
    end

    // Rounding and packing of the normalised magnitude (bit 31 is the hidden one).
    always_comb begin
        round_bit_s = mag_r[7];
        sticky_s    = |mag_r[6:0];
        inexact_s   = round_bit_s | sticky_s;
        round_up_s  = round_up_f(rm_r, sign_r, round_bit_s, sticky_s, mag_r[8]);
        sig_sum_s   = {1'b0, mag_r[30:8]} + {23'd0, round_up_s};
        // A carry out of the significand means the value became the next power of two.
        if (sig_sum_s[23]) begin
            sig_final_s = 23'd0;
            exp_final_s = exp_r + 8'd1;
        end else begin
            sig_final_s = sig_sum_s[22:0];
            exp_final_s = exp_r;
        end
        if (mag_r == 32'd0) begin
            packed_s = 32'h0000_0000;
        end else begin
            packed_s = {sign_r, exp_final_s, sig_final_s};
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    if (mag_in_s == 32'd0) begin
                        state_next_s = ROUND;
                    end else begin
                        state_next_s = NORM;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            NORM: begin
                if (mag_r[31]) begin
                    state_next_s = ROUND;
                end else begin
                    state_next_s = NORM;
                end
            end
            ROUND:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Datapath: operand capture, one-bit normalisation shifts, result update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sign_r   <= 1'b0;
            mag_r    <= 32'd0;
            rm_r     <= 3'd0;
            exp_r    <= 8'd0;
            done_r   <= 1'b0;
            result_r <= 32'd0;
            nx_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        sign_r <= sign_in_s;
                        mag_r  <= mag_in_s;
                        rm_r   <= rm_i;
                        exp_r  <= 8'd158;
                    end
                end
                NORM: begin
                    if (!mag_r[31]) begin
                        mag_r <= {mag_r[30:0], 1'b0};
                        exp_r <= exp_r - 8'd1;
                    end
                end
                ROUND: begin
                    result_r <= packed_s;
                    nx_r     <= (mag_r == 32'd0) ? 1'b0 : inexact_s;
                    done_r   <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign result_o = result_r;
    assign nx_o     = nx_r;

endmodule
